mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data load/store share one memory port.
// Data normally has priority; a saturating starvation counter lets a waiting fetch through.
module mem_arbiter #(
    parameter int STARVE_MAX = 3,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [2:0]    d_rw_type,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_rw_type,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stall_if,
    output logic          stall_mem
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic          owner_reg;
    logic [SW-1:0] starve_cnt_reg;

    logic if_elig;
    logic d_elig;
    logic grant_fetch;
    logic grant_data;

    // A requester is never eligible in its own ack cycle, so a held req is not regranted.
    assign if_elig     = if_req & ~if_ack;
    assign d_elig      = d_req & ~d_ack;
    assign grant_fetch = (state_reg == IDLE) & if_elig &
                         (~d_elig | (starve_cnt_reg == STARVE_LIMIT));
    assign grant_data  = (state_reg == IDLE) & d_elig & ~grant_fetch;

    assign mem_en    = (state_reg == ISSUE);
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = d_req & ~d_ack;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_fetch || grant_data) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (mem_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg      <= 1'b0;
            starve_cnt_reg <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_rw_type    <= 3'b000;
        end else if (grant_fetch) begin
            owner_reg      <= 1'b0;
            starve_cnt_reg <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= if_addr;
            mem_wdata      <= '0;
            mem_rw_type    <= 3'b010;
        end else if (grant_data) begin
            owner_reg   <= 1'b1;
            mem_we      <= d_we;
            mem_addr    <= d_addr;
            mem_wdata   <= d_wdata;
            mem_rw_type <= d_rw_type;
            if (if_elig && (starve_cnt_reg != STARVE_LIMIT)) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
        end
    end

    // Completion: capture into the owner's read register and pulse only its ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            d_rdata  <= '0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            if ((state_reg == WAIT) && mem_ready) begin
                if (owner_reg) begin
                    d_rdata <= mem_rdata;
                    d_ack   <= 1'b1;
                end else begin
                    if_rdata <= mem_rdata;
                    if_ack   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts grants and acks,
// a separate monitor compares them against the DUT as they appear.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 3;
    localparam int NTX        = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [2:0]  d_rw_type = 3'b000;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_rw_type;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        stall_if;
    logic        stall_mem;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rw_type(d_rw_type), .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rw_type(mem_rw_type), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  rwt;
    } grant_t;

    typedef struct {
        int          cyc;
        logic        is_data;
        logic        chk;
        logic [31:0] data;
    } ack_t;

    grant_t grant_q[$];
    ack_t   ack_q[$];
    int     cyc = 0;
    int     compared = 0;
    int     mismatched = 0;
    bit     resp_block = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: one transaction at a time; an arbitration decision happens whenever
    // no transaction is in flight, ack cycles excluding the just-completed requester.
    initial begin
        int   phase;
        int   starve;
        bit   owner_d;
        bit   cur_we;
        bit   ack_f;
        bit   ack_d;
        bit   nf;
        bit   nd;
        bit   fe;
        bit   de;
        phase = 0; starve = 0; owner_d = 0; cur_we = 0; ack_f = 0; ack_d = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                phase = 0; starve = 0; ack_f = 0; ack_d = 0;
                grant_q.delete();
                ack_q.delete();
            end else begin
                nf = 0; nd = 0;
                fe = if_req && !ack_f;
                de = d_req && !ack_d;
                if (phase == 0) begin
                    if (fe && (!de || starve == STARVE_MAX)) begin
                        grant_q.push_back('{cyc, 1'b0, if_addr, 32'h0, 3'b010});
                        owner_d = 0; cur_we = 0; starve = 0; phase = 1;
                    end else if (de) begin
                        grant_q.push_back('{cyc, d_we, d_addr, d_wdata, d_rw_type});
                        owner_d = 1; cur_we = d_we; phase = 1;
                        if (fe && starve < STARVE_MAX) starve++;
                    end
                end else if (phase == 1) begin
                    phase = 2;
                end else if (mem_ready) begin
                    ack_q.push_back('{cyc, owner_d, !(owner_d && cur_we), mem_rdata});
                    if (owner_d) nd = 1; else nf = 1;
                    phase = 0;
                end
                ack_f = nf;
                ack_d = nd;
            end
        end
    end

    // Monitor: compares whatever the DUT presents with the model's expectations for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_outputs",
                      {mem_en, mem_we, mem_addr, mem_wdata, mem_rw_type, if_rdata, d_rdata, if_ack, d_ack},
                      '0);
            end else begin
                while (grant_q.size() > 0 && grant_q[0].cyc < cyc) begin
                    void'(grant_q.pop_front());
                    note_fail("grant_missing");
                end
                while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                    void'(ack_q.pop_front());
                    note_fail("ack_missing");
                end
                if (mem_en) begin
                    if (grant_q.size() > 0 && grant_q[0].cyc == cyc) begin
                        grant_t g;
                        g = grant_q.pop_front();
                        check("grant_fields", {mem_we, mem_addr, mem_wdata, mem_rw_type},
                              {g.we, g.addr, g.wdata, g.rwt});
                    end else begin
                        note_fail("mem_en_unexpected");
                    end
                end
                if (if_ack && d_ack) note_fail("both_acks");
                if (if_ack || d_ack) begin
                    if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
                        ack_t a;
                        a = ack_q.pop_front();
                        check("ack_owner", {if_ack, d_ack}, {~a.is_data, a.is_data});
                        if (a.chk) check("ack_rdata", a.is_data ? d_rdata : if_rdata, a.data);
                    end else begin
                        note_fail("ack_unexpected");
                    end
                end
                check("stall_if", stall_if, if_req & ~if_ack);
                check("stall_mem", stall_mem, d_req & ~d_ack);
            end
        end
    end

    // Memory responder: random ready noise in the issue cycle, then 0..5 wait cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (mem_en && rst_n) begin
                int d;
                bit aborted;
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
                d = $urandom_range(0, 5);
                aborted = 0;
                for (int i = 0; i < d || resp_block; i++) begin
                    @(posedge clk);
                    #1;
                    mem_ready = 1'b0;
                    if (!rst_n) begin
                        aborted = 1;
                        break;
                    end
                end
                if (!aborted) begin
                    @(posedge clk);
                    #1;
                    mem_ready = 1'b1;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    task automatic wait_ack(input bit is_data);
        int t;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!(is_data ? d_ack : if_ack) && t < 200);
        if (t >= 200) note_fail(is_data ? "d_ack_timeout" : "if_ack_timeout");
    endtask

    initial begin
        logic [31:0] r;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        fork
            begin
                for (int n = 0; n < NTX; n++) begin
                    int gap;
                    r = $urandom;
                    if_addr = {r[31:2], 2'b00};
                    if_req = 1'b1;
                    wait_ack(1'b0);
                    @(posedge clk);
                    #1;
                    gap = $urandom_range(0, 3);
                    if (gap > 0) begin
                        if_req = 1'b0;
                        if_addr = $urandom;
                        repeat (gap) begin @(posedge clk); #1; end
                    end
                end
                if_req = 1'b0;
            end
            begin
                for (int n = 0; n < NTX; n++) begin
                    int gap;
                    d_we = 1'($urandom_range(0, 1));
                    d_addr = $urandom;
                    d_wdata = $urandom;
                    r = $urandom;
                    d_rw_type = r[2:0];
                    d_req = 1'b1;
                    wait_ack(1'b1);
                    @(posedge clk);
                    #1;
                    gap = $urandom_range(0, 2);
                    if (gap > 0) begin
                        d_req = 1'b0;
                        d_addr = $urandom;
                        repeat (gap) begin @(posedge clk); #1; end
                    end
                end
                d_req = 1'b0;
            end
        join

        // Reset during the wait phase of a load, then the same load is reissued.
        repeat (5) @(posedge clk);
        #1;
        resp_block = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h0000_0040;
        d_rw_type = 3'b010;
        d_req = 1'b1;
        begin
            int t;
            t = 0;
            while (!mem_en && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (!mem_en) note_fail("reset_test_no_issue");
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        resp_block = 1'b0;
        #1;
        wait_ack(1'b1);
        @(posedge clk);
        #1;
        d_req = 1'b0;

        repeat (10) @(posedge clk);
        #1;
        check("grant_queue_drained", 128'(grant_q.size()), 128'd0);
        check("ack_queue_drained", 128'(ack_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule
